// File: rtl/axis_pos_tracker_pkg.sv
// Shared definitions for the AXI4-Stream position tracker.
//   state_t : tracker FSM states
//   sat_inc : increment that sticks at the largest w-bit value
package axis_pos_tracker_pkg;

  typedef enum logic [2:0] {
    S_WAIT_SOF,
    S_FSYNC,
    S_LSYNC,
    S_UPD,
    S_STREAM
  } state_t;

  // Callers cast the result back down to their counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] vmax;
    vmax = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= vmax) ? vmax : v + 32'd1;
  endfunction

endpackage

// File: rtl/axis_pos_tracker_if.sv
// AXI4-Stream beat bundle.
//   master : drives tvalid/tdata/tuser/tlast, receives tready
//   slave  : receives tvalid/tdata/tuser/tlast, drives tready
// tuser carries start-of-frame, tlast carries end-of-line.
interface axis_pos_tracker_if #(
  parameter int DW = 8
);
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tuser;
  logic          tlast;
  logic          tready;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/axis_pos_tracker.sv
// Pass-through AXI4-Stream position tracker feeding the window shifter.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   s_axis / m_axis     : upstream slave and downstream master stream
//   fsync, lsync        : frame / line start pulses (decoded from state)
//   col_idx(_next)      : index of the next presented pixel (+1), col_update strobe
//   row_idx(_next)      : current line index (+1), row_update strobe
//   frame_width/height  : geometry of the last completed line / frame
//   err_sof             : one-cycle pulse when SOF truncated a line
module axis_pos_tracker
  import axis_pos_tracker_pkg::*;
#(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_IMG_WBITS   = 12,
  parameter int C_IMG_HBITS   = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  axis_pos_tracker_if.slave      s_axis,
  axis_pos_tracker_if.master     m_axis,
  output logic                   fsync,
  output logic                   lsync,
  output logic [C_IMG_WBITS-1:0] col_idx,
  output logic [C_IMG_WBITS-1:0] col_idx_next,
  output logic                   col_update,
  output logic [C_IMG_HBITS-1:0] row_idx,
  output logic [C_IMG_HBITS-1:0] row_idx_next,
  output logic                   row_update,
  output logic [C_IMG_WBITS-1:0] frame_width,
  output logic [C_IMG_HBITS-1:0] frame_height,
  output logic                   err_sof
);

  state_t                 state_q;
  logic                   sof_ok_q;
  logic                   err_sof_q;
  logic [C_IMG_WBITS-1:0] col_cnt_q;
  logic [C_IMG_HBITS-1:0] row_cnt_q;
  logic [C_IMG_WBITS-1:0] frame_width_q;
  logic [C_IMG_HBITS-1:0] frame_height_q;

  logic [C_IMG_WBITS-1:0] col_inc;
  logic [C_IMG_WBITS-1:0] col_inc2;
  logic [C_IMG_HBITS-1:0] row_inc;
  logic                   sof_hold;
  logic                   xfer;
  logic                   s_tready_c;
  logic                   m_tvalid_c;
  logic [C_PIXEL_WIDTH-1:0] pix;

  assign col_inc  = C_IMG_WBITS'(sat_inc(32'(col_cnt_q), C_IMG_WBITS));
  assign col_inc2 = C_IMG_WBITS'(sat_inc(32'(col_inc), C_IMG_WBITS));
  assign row_inc  = C_IMG_HBITS'(sat_inc(32'(row_cnt_q), C_IMG_HBITS));

  // sof_ok marks the SOF beat that has already been through the sync
  // sequence, so it is passed instead of held a second time.
  assign sof_hold = s_axis.tvalid && s_axis.tuser && !sof_ok_q;
  // Written without m_tvalid_c so the handshake has no comb loop.
  assign xfer     = (state_q == S_STREAM) && s_axis.tvalid && !sof_hold && m_axis.tready;

  assign pix           = s_axis.tdata;
  assign m_axis.tdata  = pix;
  assign m_axis.tuser  = s_axis.tuser;
  assign m_axis.tlast  = s_axis.tlast;
  assign m_axis.tvalid = m_tvalid_c;
  assign s_axis.tready = s_tready_c;

  assign fsync        = (state_q == S_FSYNC);
  assign lsync        = (state_q == S_LSYNC);
  assign row_update   = (state_q == S_UPD);
  assign row_idx      = row_cnt_q;
  assign row_idx_next = row_inc;
  assign frame_width  = frame_width_q;
  assign frame_height = frame_height_q;
  assign err_sof      = err_sof_q;

  always_comb begin
    s_tready_c   = 1'b0;
    m_tvalid_c   = 1'b0;
    col_update   = 1'b0;
    col_idx      = col_cnt_q;
    col_idx_next = col_inc;
    case (state_q)
      S_WAIT_SOF: s_tready_c = !sof_hold;
      S_UPD: begin
        col_update   = 1'b1;
        col_idx      = '0;
        col_idx_next = C_IMG_WBITS'(1);
      end
      S_STREAM: begin
        m_tvalid_c = s_axis.tvalid && !sof_hold;
        s_tready_c = m_axis.tready && !sof_hold;
        // Strobe describes the position after this beat is consumed.
        if (xfer) begin
          col_update   = 1'b1;
          col_idx      = col_inc;
          col_idx_next = col_inc2;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_WAIT_SOF;
      sof_ok_q       <= 1'b0;
      err_sof_q      <= 1'b0;
      col_cnt_q      <= '0;
      row_cnt_q      <= '0;
      frame_width_q  <= '0;
      frame_height_q <= '0;
    end else begin
      err_sof_q <= 1'b0;
      case (state_q)
        S_WAIT_SOF: if (sof_hold) state_q <= S_FSYNC;
        S_FSYNC: begin
          sof_ok_q  <= 1'b1;
          row_cnt_q <= '0;
          state_q   <= S_LSYNC;
        end
        S_LSYNC: begin
          col_cnt_q <= '0;
          state_q   <= S_UPD;
        end
        S_UPD: state_q <= S_STREAM;
        S_STREAM: begin
          if (sof_hold) begin
            // A line cut short by SOF still counts toward the frame height.
            if (col_cnt_q == '0) begin
              frame_height_q <= row_cnt_q;
            end else begin
              err_sof_q      <= 1'b1;
              frame_height_q <= row_inc;
            end
            state_q <= S_FSYNC;
          end else if (xfer) begin
            col_cnt_q <= col_inc;
            sof_ok_q  <= 1'b0;
            if (s_axis.tlast) begin
              frame_width_q <= col_inc;
              row_cnt_q     <= row_inc;
              state_q       <= S_LSYNC;
            end
          end
        end
        default: state_q <= S_WAIT_SOF;
      endcase
    end
  end

endmodule
